// File: rtl/matmul_tile_scheduler.sv
// -----------------------------------------------------------------------------
// matmul_tile_scheduler
//
// Sequencer for a tiled systolic matrix multiply C = A x B. It walks the output
// tiles in row-major order and, within each tile, the chunks of the inner
// dimension. For every chunk it presents the operand-RAM chunk addresses,
// pulses the systolic core's active-low reset for one cycle, and tells the
// accumulator whether to clear (first chunk) or accumulate. A finished tile is
// announced with a one-cycle out_valid strobe; done pulses with the last one.
//
// Ports
//   clk              : clock, rising edge
//   rst_n            : asynchronous active-low reset
//   start            : begin a full run (only looked at while idle)
//   systolic_finish  : core has finished the current chunk
//   accumulator_done : core accumulator holds a completed tile
//   counter_A        : RAM A chunk address, k + K_STEPS*row
//   counter_B        : RAM B chunk address, k + K_STEPS*col
//   core_rst_n       : active-low reset to the systolic core
//   reset_acc        : 0 = clear accumulator, 1 = accumulate
//   out_valid        : one-cycle strobe, core output is a valid tile
//   tile_row         : row index of the current tile
//   tile_col         : column index of the current tile
//   tile_index       : linear tile number, row*COL_TILES + col
//   busy             : run in progress
//   done             : one-cycle pulse, run complete
//
// All three matrix dimensions must be multiples of BLOCK_SIZE, and the largest
// address (ROW_TILES*K_STEPS-1 or COL_TILES*K_STEPS-1) must fit in WIDTH bits.
// -----------------------------------------------------------------------------
module matmul_tile_scheduler #(
    parameter int WIDTH           = 16,
    parameter int BLOCK_SIZE      = 2,
    parameter int INNER_DIMENSION = 8,
    parameter int ROW_SIZE_MAT_A  = 10,
    parameter int COL_SIZE_MAT_B  = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             systolic_finish,
    input  logic             accumulator_done,
    output logic [WIDTH-1:0] counter_A,
    output logic [WIDTH-1:0] counter_B,
    output logic             core_rst_n,
    output logic             reset_acc,
    output logic             out_valid,
    output logic [15:0]      tile_row,
    output logic [15:0]      tile_col,
    output logic [WIDTH-1:0] tile_index,
    output logic             busy,
    output logic             done
);

    localparam int K_STEPS   = INNER_DIMENSION / BLOCK_SIZE;
    localparam int ROW_TILES = ROW_SIZE_MAT_A / BLOCK_SIZE;
    localparam int COL_TILES = COL_SIZE_MAT_B / BLOCK_SIZE;
    localparam int NUM_TILES = ROW_TILES * COL_TILES;

    localparam logic [WIDTH-1:0] K_STEPS_W = WIDTH'(K_STEPS);
    localparam logic [WIDTH-1:0] K_LAST    = WIDTH'(K_STEPS - 1);
    localparam logic [WIDTH-1:0] LAST_TILE = WIDTH'(NUM_TILES - 1);
    localparam logic [WIDTH-1:0] ONE_W     = WIDTH'(1);
    localparam logic [15:0]      COL_LAST  = 16'(COL_TILES - 1);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RUN,
        WAIT_ACC,
        EMIT
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] k;
    logic [WIDTH-1:0] k_inc;
    logic [15:0]      next_row;
    logic [15:0]      next_col;
    logic             last_tile;

    // Chunk address: unsigned, truncated to WIDTH bits.
    function automatic logic [WIDTH-1:0] chunk_addr(input logic [WIDTH-1:0] kk,
                                                    input logic [15:0]      idx);
        return kk + WIDTH'(idx) * K_STEPS_W;
    endfunction

    // Position of the tile that follows the current one (row-major walk).
    always_comb begin
        k_inc     = k + ONE_W;
        next_row  = tile_row;
        next_col  = tile_col + 16'd1;
        if (tile_col == COL_LAST) begin
            next_col = '0;
            next_row = tile_row + 16'd1;
        end
        last_tile = (tile_index == LAST_TILE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            counter_A  <= '0;
            counter_B  <= '0;
            core_rst_n <= 1'b0;
            reset_acc  <= 1'b0;
            out_valid  <= 1'b0;
            tile_row   <= '0;
            tile_col   <= '0;
            tile_index <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            // Strobes last exactly one cycle unless re-asserted below.
            out_valid <= 1'b0;
            done      <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        k          <= '0;
                        tile_row   <= '0;
                        tile_col   <= '0;
                        tile_index <= '0;
                        counter_A  <= '0;
                        counter_B  <= '0;
                        core_rst_n <= 1'b0;
                        reset_acc  <= 1'b0;
                        busy       <= 1'b1;
                        state      <= LOAD;
                    end
                end

                // Addresses were presented on entry; the core is held in reset
                // for this one cycle while the RAMs complete their read.
                LOAD: begin
                    core_rst_n <= 1'b1;
                    state      <= RUN;
                end

                RUN: begin
                    if (systolic_finish) begin
                        core_rst_n <= 1'b0;
                        if (k != K_LAST) begin
                            k         <= k_inc;
                            counter_A <= chunk_addr(k_inc, tile_row);
                            counter_B <= chunk_addr(k_inc, tile_col);
                            reset_acc <= 1'b1;
                            state     <= LOAD;
                        end else if (accumulator_done) begin
                            // Accumulator already complete: skip WAIT_ACC.
                            out_valid <= 1'b1;
                            done      <= last_tile;
                            state     <= EMIT;
                        end else begin
                            state <= WAIT_ACC;
                        end
                    end
                end

                WAIT_ACC: begin
                    if (accumulator_done) begin
                        out_valid <= 1'b1;
                        done      <= last_tile;
                        state     <= EMIT;
                    end
                end

                // tile_row/tile_col/tile_index still describe the emitted tile
                // here; they advance only as this state is left.
                EMIT: begin
                    if (last_tile) begin
                        busy      <= 1'b0;
                        reset_acc <= 1'b0;
                        state     <= IDLE;
                    end else begin
                        k          <= '0;
                        tile_row   <= next_row;
                        tile_col   <= next_col;
                        tile_index <= tile_index + ONE_W;
                        counter_A  <= chunk_addr('0, next_row);
                        counter_B  <= chunk_addr('0, next_col);
                        core_rst_n <= 1'b0;
                        reset_acc  <= 1'b0;
                        state      <= LOAD;
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_tile_scheduler.sv
// -----------------------------------------------------------------------------
// tb_matmul_tile_scheduler
//
// Directed bench for matmul_tile_scheduler with default parameters
// (K_STEPS = 4, 5 x 3 tiles). The bench plays the part of the systolic core:
// it raises systolic_finish a fixed time after each core release and raises
// accumulator_done either together with the last finish or after a delay.
// -----------------------------------------------------------------------------
module tb_matmul_tile_scheduler;

    localparam int WIDTH = 16;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             systolic_finish;
    logic             accumulator_done;
    logic [WIDTH-1:0] counter_A;
    logic [WIDTH-1:0] counter_B;
    logic             core_rst_n;
    logic             reset_acc;
    logic             out_valid;
    logic [15:0]      tile_row;
    logic [15:0]      tile_col;
    logic [WIDTH-1:0] tile_index;
    logic             busy;
    logic             done;

    int vectors     = 0;
    int miscompares = 0;
    int pulses      = 0;

    matmul_tile_scheduler #(
        .WIDTH           (WIDTH),
        .BLOCK_SIZE      (2),
        .INNER_DIMENSION (8),
        .ROW_SIZE_MAT_A  (10),
        .COL_SIZE_MAT_B  (6)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .start            (start),
        .systolic_finish  (systolic_finish),
        .accumulator_done (accumulator_done),
        .counter_A        (counter_A),
        .counter_B        (counter_B),
        .core_rst_n       (core_rst_n),
        .reset_acc        (reset_acc),
        .out_valid        (out_valid),
        .tile_row         (tile_row),
        .tile_col         (tile_col),
        .tile_index       (tile_index),
        .busy             (busy),
        .done             (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count tile strobes as seen on the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid) pulses <= pulses + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: observed %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, "_counter_A"},  counter_A,  0);
        check_val({tag, "_counter_B"},  counter_B,  0);
        check_val({tag, "_core_rst_n"}, core_rst_n, 0);
        check_val({tag, "_reset_acc"},  reset_acc,  0);
        check_val({tag, "_out_valid"},  out_valid,  0);
        check_val({tag, "_tile_row"},   tile_row,   0);
        check_val({tag, "_tile_col"},   tile_col,   0);
        check_val({tag, "_tile_index"}, tile_index, 0);
        check_val({tag, "_busy"},       busy,       0);
        check_val({tag, "_done"},       done,       0);
    endtask

    // Run one tile starting from its first LOAD cycle, ending one cycle after
    // EMIT. acc_delay = 0 raises accumulator_done with the last finish.
    // noise injects inputs that must be ignored (start while busy, early
    // accumulator_done, systolic_finish while waiting on the accumulator).
    task automatic do_tile(input int row, input int col, input int acc_delay, input bit noise);
        int idx;
        idx = row * 3 + col;
        for (int kk = 0; kk < 4; kk++) begin
            check_val("load_counter_A", counter_A, kk + 4 * row);
            check_val("load_counter_B", counter_B, kk + 4 * col);
            check_val("load_core_rst_n", core_rst_n, 0);
            check_val("load_reset_acc", reset_acc, (kk != 0) ? 1 : 0);
            check_val("load_busy", busy, 1);
            if (row == 4 && col == 2 && kk == 3) begin
                check_val("last_chunk_counter_A", counter_A, 19);
                check_val("last_chunk_counter_B", counter_B, 11);
            end
            tick();
            check_val("run_core_rst_n", core_rst_n, 1);
            check_val("run_tile_row", tile_row, row);
            check_val("run_tile_col", tile_col, col);
            check_val("run_tile_index", tile_index, idx);
            if (noise) start = 1'b1;
            repeat (4) tick();
            start = 1'b0;
            check_val("run_hold_counter_A", counter_A, kk + 4 * row);
            check_val("run_hold_core_rst_n", core_rst_n, 1);
            systolic_finish = 1'b1;
            if (kk == 3 && acc_delay == 0) accumulator_done = 1'b1;
            if (noise && kk < 3) accumulator_done = 1'b1;
            tick();
            systolic_finish  = 1'b0;
            accumulator_done = 1'b0;
        end
        if (acc_delay > 0) begin
            for (int d = 0; d < acc_delay; d++) begin
                check_val("wait_core_rst_n", core_rst_n, 0);
                check_val("wait_out_valid", out_valid, 0);
                if (noise) systolic_finish = 1'b1;
                tick();
                systolic_finish = 1'b0;
            end
            accumulator_done = 1'b1;
            tick();
            accumulator_done = 1'b0;
        end
        check_val("emit_out_valid", out_valid, 1);
        check_val("emit_tile_row", tile_row, row);
        check_val("emit_tile_col", tile_col, col);
        check_val("emit_tile_index", tile_index, idx);
        check_val("emit_done", done, (idx == 14) ? 1 : 0);
        tick();
        check_val("post_emit_out_valid", out_valid, 0);
    endtask

    initial begin
        int base_pulses;
        int delay;

        rst_n            = 1'b0;
        start            = 1'b0;
        systolic_finish  = 1'b0;
        accumulator_done = 1'b0;

        // Reset state, then idle after release.
        repeat (2) tick();
        check_all_zero("in_reset");
        rst_n = 1'b1;
        repeat (2) tick();
        check_all_zero("idle");

        // Full run with a mix of accumulator timings.
        base_pulses = pulses;
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("start_busy", busy, 1);
        check_val("start_counter_A", counter_A, 0);
        check_val("start_counter_B", counter_B, 0);
        check_val("start_core_rst_n", core_rst_n, 0);
        for (int r = 0; r < 5; r++) begin
            for (int c = 0; c < 3; c++) begin
                delay = (r * 3 + c == 0) ? 0 : (r * 3 + c == 1) ? 7 : (r * 3 + c) % 3;
                do_tile(r, c, delay, (r * 3 + c == 5));
                if (r == 0 && c == 2) begin
                    check_val("wrap_counter_A", counter_A, 4);
                    check_val("wrap_counter_B", counter_B, 0);
                    check_val("wrap_tile_row", tile_row, 1);
                    check_val("wrap_tile_col", tile_col, 0);
                end
            end
        end
        check_val("end_busy", busy, 0);
        check_val("end_done", done, 0);
        check_val("end_core_rst_n", core_rst_n, 0);
        check_val("tile_pulse_count", pulses - base_pulses, 15);
        repeat (3) tick();
        check_val("idle_after_run_busy", busy, 0);
        check_val("idle_after_run_out_valid", out_valid, 0);

        // Second run, aborted by reset partway into tile 7.
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int t = 0; t < 7; t++) do_tile(t / 3, t % 3, 1, 1'b0);
        repeat (2) tick();
        check_val("pre_abort_counter_A", counter_A, 8);
        check_val("pre_abort_tile_index", tile_index, 7);
        base_pulses = pulses;
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_reset");
        systolic_finish  = 1'b1;
        accumulator_done = 1'b1;
        repeat (3) tick();
        systolic_finish  = 1'b0;
        accumulator_done = 1'b0;
        check_all_zero("held_reset");
        rst_n = 1'b1;
        repeat (2) tick();
        check_all_zero("after_abort");
        check_val("abort_no_pulse", pulses - base_pulses, 0);

        // Restart resumes at tile 0.
        start = 1'b1;
        tick();
        start = 1'b0;
        check_val("restart_busy", busy, 1);
        do_tile(0, 0, 0, 1'b0);
        check_val("restart_next_counter_B", counter_B, 4);
        check_val("restart_next_tile_index", tile_index, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
